// File: rtl/alu_seq_loader.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_loader
// Purpose  : Debounced three-button operand/opcode loader driving a registered
//            ALU result with zero/carry/overflow flags.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module alu_seq_loader #(
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clockCustom,
  input  logic                  resetGral,
  input  logic [DATA_WIDTH-1:0] switch,
  input  logic                  button1,
  input  logic                  button2,
  input  logic                  button3,
  output logic [DATA_WIDTH-1:0] LED,
  output logic                  flagZero,
  output logic                  flagCarry,
  output logic                  flagOvf,
  output logic                  opError,
  output logic                  ready
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] c_WIDTH_VAL = DATA_WIDTH'(DATA_WIDTH);
  localparam int c_MSB = DATA_WIDTH - 1;

  localparam logic [3:0] c_OP_ADD = 4'b0001;
  localparam logic [3:0] c_OP_SUB = 4'b0010;
  localparam logic [3:0] c_OP_AND = 4'b0011;
  localparam logic [3:0] c_OP_OR  = 4'b0101;
  localparam logic [3:0] c_OP_XOR = 4'b0111;
  localparam logic [3:0] c_OP_SRA = 4'b1000;
  localparam logic [3:0] c_OP_SRL = 4'b1100;
  localparam logic [3:0] c_OP_NOR = 4'b1110;

  localparam logic [2:0] c_EMPTY   = 3'd0;
  localparam logic [2:0] c_HAVE_A  = 3'd1;
  localparam logic [2:0] c_HAVE_B  = 3'd2;
  localparam logic [2:0] c_HAVE_AB = 3'd3;
  localparam logic [2:0] c_RUN     = 3'd4;

  logic [2:0] w_buttons;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [1:0] r_fill;
  logic [2:0] w_pulse;

  assign w_buttons = {button3, button2, button1};

  // r_fill marks when r_sync2 carries real post-reset samples rather than reset zeros.
  always_ff @(posedge clockCustom) begin
    if (resetGral) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_fill  <= '0;
    end else begin
      r_sync1 <= w_buttons;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic [c_CNT_W-1:0] r_cnt;
      logic               r_armed;
      logic               r_pulse;

      // A press only counts once the button has been seen low since reset.
      always_ff @(posedge clockCustom) begin
        if (resetGral) begin
          r_cnt   <= '0;
          r_armed <= 1'b0;
          r_pulse <= 1'b0;
        end else begin
          r_pulse <= 1'b0;
          if (r_fill[1]) begin
            if (!r_sync2[gi]) begin
              r_cnt   <= '0;
              r_armed <= 1'b1;
            end else if (r_armed && (r_cnt != c_CNT_MAX)) begin
              r_cnt <= r_cnt + c_CNT_W'(1);
              if (r_cnt == c_CNT_LAST) begin
                r_pulse <= 1'b1;
              end
            end
          end
        end
      end

      assign w_pulse[gi] = r_pulse;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_regA;
  logic [DATA_WIDTH-1:0] r_regB;
  logic [3:0]            r_regOp;
  logic [2:0]            r_state;
  logic [2:0]            w_nextState;
  logic                  r_exec;
  logic                  w_opValid;
  logic                  w_haveA;
  logic                  w_haveB;
  logic                  w_accept;

  always_comb begin
    w_opValid = 1'b0;
    case (switch[3:0])
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
      c_OP_XOR, c_OP_SRA, c_OP_SRL, c_OP_NOR: w_opValid = 1'b1;
      default:                                w_opValid = 1'b0;
    endcase
  end

  // Operand presence is judged after this cycle's loads are applied.
  assign w_haveA  = w_pulse[0] || (r_state == c_HAVE_A) || (r_state == c_HAVE_AB) || (r_state == c_RUN);
  assign w_haveB  = w_pulse[1] || (r_state == c_HAVE_B) || (r_state == c_HAVE_AB) || (r_state == c_RUN);
  assign w_accept = w_pulse[2] && w_opValid && w_haveA && w_haveB;

  always_comb begin
    w_nextState = r_state;
    if (r_state != c_RUN) begin
      if (w_accept)                w_nextState = c_RUN;
      else if (w_haveA && w_haveB) w_nextState = c_HAVE_AB;
      else if (w_haveA)            w_nextState = c_HAVE_A;
      else if (w_haveB)            w_nextState = c_HAVE_B;
      else                         w_nextState = c_EMPTY;
    end
  end

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH-1:0] w_sra;
  logic [DATA_WIDTH-1:0] w_srl;
  logic                  w_shiftBig;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_carry;
  logic                  w_ovf;

  assign w_sum      = {1'b0, r_regA} + {1'b0, r_regB};
  assign w_diff     = {1'b0, r_regA} - {1'b0, r_regB};
  assign w_shiftBig = (r_regB >= c_WIDTH_VAL);
  assign w_sra      = $signed(r_regA) >>> r_regB;
  assign w_srl      = r_regA >> r_regB;

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (r_regOp)
      c_OP_ADD: begin
        w_result = w_sum[DATA_WIDTH-1:0];
        w_carry  = w_sum[DATA_WIDTH];
        w_ovf    = (r_regA[c_MSB] == r_regB[c_MSB]) && (w_sum[c_MSB] != r_regA[c_MSB]);
      end
      c_OP_SUB: begin
        w_result = w_diff[DATA_WIDTH-1:0];
        w_carry  = w_diff[DATA_WIDTH];
        w_ovf    = (r_regA[c_MSB] != r_regB[c_MSB]) && (w_diff[c_MSB] != r_regA[c_MSB]);
      end
      c_OP_AND: w_result = r_regA & r_regB;
      c_OP_OR:  w_result = r_regA | r_regB;
      c_OP_XOR: w_result = r_regA ^ r_regB;
      c_OP_SRA: w_result = w_shiftBig ? {DATA_WIDTH{r_regA[c_MSB]}} : w_sra;
      c_OP_SRL: w_result = w_shiftBig ? '0 : w_srl;
      c_OP_NOR: w_result = ~(r_regA | r_regB);
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge clockCustom) begin
    if (resetGral) begin
      r_regA    <= '0;
      r_regB    <= '0;
      r_regOp   <= '0;
      r_state   <= c_EMPTY;
      r_exec    <= 1'b0;
      LED       <= '0;
      flagZero  <= 1'b0;
      flagCarry <= 1'b0;
      flagOvf   <= 1'b0;
      opError   <= 1'b0;
      ready     <= 1'b0;
    end else begin
      if (w_pulse[0]) r_regA <= switch;
      if (w_pulse[1]) r_regB <= switch;
      if (w_pulse[2]) begin
        if (w_accept) begin
          r_regOp <= switch[3:0];
          opError <= 1'b0;
        end else begin
          opError <= 1'b1;
        end
      end
      r_state <= w_nextState;
      // Live mode: an operand reload while running recomputes with the stored op.
      r_exec  <= w_accept || ((r_state == c_RUN) && (w_pulse[0] || w_pulse[1]));
      if (r_exec) begin
        LED       <= w_result;
        flagZero  <= (w_result == '0);
        flagCarry <= w_carry;
        flagOvf   <= w_ovf;
        ready     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_loader
// Purpose  : Directed plus randomized bench for alu_seq_loader with a
//            behavioural result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_loader;

  localparam int DW = 8;
  localparam int DB = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] switchVal;
  logic          b1, b2, b3;
  logic [DW-1:0] led;
  logic          fZero, fCarry, fOvf, opErr, rdy;

  int nVectors;
  int nMiscompares;

  // Reference state
  int mA, mB, mOp;
  bit mHaveA, mHaveB, mRun, mErr, mReady;
  int mLed;
  bit mZ, mC, mV;

  alu_seq_loader #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DB)) dut (
    .clockCustom(clk),
    .resetGral  (rst),
    .switch     (switchVal),
    .button1    (b1),
    .button2    (b2),
    .button3    (b3),
    .LED        (led),
    .flagZero   (fZero),
    .flagCarry  (fCarry),
    .flagOvf    (fOvf),
    .opError    (opErr),
    .ready      (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit opIsValid(input int op);
    return (op == 1) || (op == 2) || (op == 3) || (op == 5) ||
           (op == 7) || (op == 8) || (op == 12) || (op == 14);
  endfunction

  function automatic int toSigned(input int v);
    return (v >= (1 << (DW - 1))) ? v - (1 << DW) : v;
  endfunction

  task automatic modelReset();
    mA = 0; mB = 0; mOp = 0;
    mHaveA = 0; mHaveB = 0; mRun = 0; mErr = 0; mReady = 0;
    mLed = 0; mZ = 0; mC = 0; mV = 0;
  endtask

  task automatic modelCompute();
    int sa, sb, r, mask;
    mask = (1 << DW) - 1;
    sa = toSigned(mA);
    sb = toSigned(mB);
    mC = 0; mV = 0;
    case (mOp)
      1: begin
        r = mA + mB; mLed = r & mask; mC = (r > mask);
        mV = ((sa + sb) > ((1 << (DW - 1)) - 1)) || ((sa + sb) < -(1 << (DW - 1)));
      end
      2: begin
        r = mA - mB; mLed = r & mask; mC = (mA < mB);
        mV = ((sa - sb) > ((1 << (DW - 1)) - 1)) || ((sa - sb) < -(1 << (DW - 1)));
      end
      3:  mLed = mA & mB;
      5:  mLed = mA | mB;
      7:  mLed = mA ^ mB;
      8:  mLed = (mB >= DW) ? ((sa < 0) ? mask : 0) : ((sa >>> mB) & mask);
      12: mLed = (mB >= DW) ? 0 : (mA >> mB);
      14: mLed = (~(mA | mB)) & mask;
      default: mLed = 0;
    endcase
    mZ = (mLed == 0);
    mReady = 1;
  endtask

  task automatic modelApply(input bit p1, input bit p2, input bit p3, input int sw);
    bit exec, wasRun;
    wasRun = mRun;
    exec = 0;
    if (p1) begin mA = sw; mHaveA = 1; end
    if (p2) begin mB = sw; mHaveB = 1; end
    if (p3) begin
      if (opIsValid(sw & 15) && mHaveA && mHaveB) begin
        mOp = sw & 15; mRun = 1; mErr = 0; exec = 1;
      end else begin
        mErr = 1;
      end
    end
    if (wasRun && (p1 || p2)) exec = 1;
    if (exec) modelCompute();
  endtask

  task automatic checkOutputs(input string tag);
    checkEq({tag, ".LED"},   32'(led),    32'(mLed));
    checkEq({tag, ".zero"},  32'(fZero),  32'(mZ));
    checkEq({tag, ".carry"}, 32'(fCarry), 32'(mC));
    checkEq({tag, ".ovf"},   32'(fOvf),   32'(mV));
    checkEq({tag, ".err"},   32'(opErr),  32'(mErr));
    checkEq({tag, ".ready"}, 32'(rdy),    32'(mReady));
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1; b1 = 0; b2 = 0; b3 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
  endtask

  // Hold the given buttons for 'hold' cycles with a stable switch value.
  task automatic press(input logic [2:0] btn, input int sw, input int hold);
    @(posedge clk); #1;
    switchVal = DW'(sw);
    {b3, b2, b1} = btn;
    repeat (hold) @(posedge clk);
    #1 {b3, b2, b1} = 3'b000;
    repeat (8) @(posedge clk);
    #1;
    if (hold >= DB) modelApply(btn[0], btn[1], btn[2], sw);
  endtask

  initial begin
    logic [2:0] btn;
    int sw, hold;
    int validOps [8] = '{1, 2, 3, 5, 7, 8, 12, 14};
    nVectors = 0; nMiscompares = 0;
    rst = 1'b0; switchVal = '0; b1 = 0; b2 = 0; b3 = 0;
    modelReset();

    doReset();
    checkOutputs("reset");

    // Glitch gives no load; a long hold gives exactly one
    press(3'b001, 5, 10);
    press(3'b010, 2, DB + 2);
    press(3'b100, 1, DB + 2);
    checkOutputs("glitch_noload");
    press(3'b001, 5, 50);
    press(3'b100, 1, DB + 2);
    checkOutputs("hold_load");

    // ADD overflow then SUB borrow
    doReset();
    press(3'b001, 8'h7F, DB + 3);
    press(3'b010, 8'h01, DB + 3);
    press(3'b100, 1, DB + 3);
    checkOutputs("add_ovf");
    checkEq("add_ovf.directLED", 32'(led), 32'h80);
    press(3'b001, 3, DB + 3);
    press(3'b010, 5, DB + 3);
    press(3'b100, 2, DB + 3);
    checkOutputs("sub_borrow");
    checkEq("sub_borrow.directLED", 32'(led), 32'hFE);

    // Operation before both operands are present
    doReset();
    press(3'b001, 3, DB + 1);
    press(3'b100, 1, DB + 1);
    checkOutputs("order_err");
    press(3'b010, 2, DB + 1);
    press(3'b100, 1, DB + 1);
    checkOutputs("order_ok");
    checkEq("order_ok.directLED", 32'(led), 32'd5);

    // Shifts, live reload with exact latency, invalid opcode
    press(3'b001, 8'h80, DB);
    press(3'b010, 9, DB);
    press(3'b100, 8, DB);
    checkOutputs("sra_big");
    @(posedge clk); #1;
    switchVal = 8'd1; b2 = 1'b1;
    repeat (DB + 3) @(posedge clk);
    #1 checkEq("latency_early", 32'(led), 32'hFF);
    @(posedge clk);
    #1 checkEq("latency_led", 32'(led), 32'hC0);
    b2 = 1'b0;
    repeat (6) @(posedge clk);
    #1 modelApply(0, 1, 0, 1);
    checkOutputs("live_reload");
    press(3'b100, 12, DB + 1);
    checkOutputs("srl");
    press(3'b100, 0, DB + 1);
    checkOutputs("invalid_op");

    // Combined B load and op from HAVE_A
    doReset();
    press(3'b001, 8'h20, DB + 1);
    press(3'b110, 8'h01, DB + 1);
    checkOutputs("combined_b_op");

    // Reset mid-press discards the press
    @(posedge clk); #1;
    switchVal = 8'h33; b1 = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    modelReset();
    repeat (30) @(posedge clk);
    #1 b1 = 1'b0;
    repeat (8) @(posedge clk);
    #1 checkOutputs("midpress_reset");
    press(3'b010, 2, DB + 1);
    press(3'b100, 1, DB + 1);
    checkOutputs("midpress_noA");

    // Randomized presses against the reference model
    doReset();
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        doReset();
      end
      btn = 3'($urandom_range(1, 7));
      sw = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
      if (btn[2] && ($urandom_range(0, 4) != 0)) begin
        sw = (sw & 8'hF0) | validOps[$urandom_range(0, 7)];
      end
      hold = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, DB - 1)) : int'($urandom_range(DB, DB + 20));
      press(btn, sw, hold);
      checkOutputs($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_loader.md
# alu_seq_loader

Parametrised successor to the board-level `topLevelAlu` wrapper. It takes the slide switches plus three push-buttons and loads operand A, operand B and the opcode, with button synchronisation, debouncing and single-pulse edge detection. A load-order state machine rejects an operation issued before both operands are present. It drives a registered result with zero/carry/overflow flags onto the LEDs. Data width and debounce time are parameters; the ALU opcode map is unchanged.

## Interface
- `DATA_WIDTH`, 4: operand/result width, ≥4.
- `DEBOUNCE_CYCLES`, 16: consecutive synchronised-high samples required to accept a button press, ≥1.
- `clockCustom` in 1: single clock; every register is on the rising edge.
- `resetGral` in 1: synchronous, active-high reset.
- `switch` in DATA_WIDTH: operand value; bits [3:0] are the opcode when `button3` is pressed.
- `button1` in 1: load A from `switch`.
- `button2` in 1: load B from `switch`.
- `button3` in 1: load the opcode and execute.
- `LED` out DATA_WIDTH: registered result.
- `flagZero` out 1: result == 0.
- `flagCarry` out 1: carry-out for ADD, borrow for SUB; 0 otherwise.
- `flagOvf` out 1: signed overflow for ADD/SUB; 0 otherwise.
- `opError` out 1: last op request was rejected.
- `ready` out 1: LED holds a valid result for the current A, B and opcode.

## Operation
- **Button path**
  - Each button passes through a 2-flop synchroniser.
  - A per-button counter counts consecutive high samples and clears on any low sample.
  - A one-cycle `pulse` is issued in the cycle the count reaches DEBOUNCE_CYCLES.
  - No further pulse is issued until the synchronised input has been sampled low at least once.
- **Load registers**
  - `pulse1` loads `regA <= switch` and `pulse2` loads `regB <= switch`.
  - `pulse3` with a valid opcode loads `regOp <= switch[3:0]`.
- **Opcodes** (on `switch[3:0]`)
  - ADD 0001, SUB 0010, AND 0011, OR 0101, XOR 0111, SRA 1000, SRL 1100, NOR 1110.
  - Any other code is invalid: sets `opError`; `regOp`, LED, flags and `ready` are unchanged.
- **Arithmetic**
  - Operands are two's complement, DATA_WIDTH bits.
  - ADD/SUB are computed DATA_WIDTH+1 wide: carry = bit DATA_WIDTH; for SUB, borrow = (A < B) unsigned.
  - Overflow: ADD when sign(A)==sign(B) and sign(result)≠sign(A); SUB when sign(A)≠sign(B) and sign(result)≠sign(A).
  - Shift amount = B taken as unsigned. Amounts ≥ DATA_WIDTH give all-sign-bits for SRA and 0 for SRL.
- **Load-order FSM** (states EMPTY, HAVE_A, HAVE_B, HAVE_AB, RUN)
  - EMPTY: pulse1 → HAVE_A; pulse2 → HAVE_B; both together → HAVE_AB.
  - HAVE_A: pulse2 → HAVE_AB. HAVE_B: pulse1 → HAVE_AB.
  - HAVE_AB: pulse3 with a valid opcode → RUN.
  - pulse3 in EMPTY, HAVE_A or HAVE_B: sets `opError`, no state change.
  - RUN: reloading A or B (live mode) recomputes the result with the stored opcode. A new valid opcode recomputes with the new op. The FSM stays in RUN.
  - `opError` clears on the next accepted valid op.
- **Simultaneous pulses**
  - All pulses are honoured in the same cycle.
  - An op pulse in the same cycle as an A/B load executes on the newly loaded operands.
  - In EMPTY, HAVE_A or HAVE_B, the op is evaluated against the post-load state. For example, HAVE_A + pulse2 + pulse3 → RUN.
- **Reset**
  - Clears regA, regB, regOp, synchronisers, counters, FSM (→ EMPTY) and every output: LED=0, flagZero=0, flagCarry=0, flagOvf=0, opError=0, ready=0.
  - Reset mid-debounce discards the pending press. The button must be sampled low, then held again for DEBOUNCE_CYCLES, before it is accepted.

## Timing
- Button rise to pulse: 2 sync cycles + DEBOUNCE_CYCLES.
- Pulse cycle T: load registers and FSM update at edge T+1. LED, flags and `ready` update at edge T+2.
- `opError` updates at edge T+1.
- Total button-rise to LED latency is DEBOUNCE_CYCLES+4 clocks. No combinational path from inputs to outputs.
- A button held for N ≥ DEBOUNCE_CYCLES cycles gives exactly one pulse. A glitch shorter than DEBOUNCE_CYCLES gives none.

## Test plan
- Reset: drive resetGral for 2 cycles → LED=0, all flags 0, ready=0, opError=0, FSM=EMPTY.
- Glitch/hold (DEBOUNCE_CYCLES=16): button1 high 10 cycles with switch=5 → no load. Then high 50 cycles → exactly one load, regA=5.
- Sequence (DATA_WIDTH=4): A=7, B=1, op ADD.
  - Result: LED=1000, flagOvf=1, flagCarry=0, ready=1.
  - Then op SUB with A=3, B=5: LED=1110, carry(borrow)=1, ovf=0.
- Order error: after reset, load A=3 only, press op ADD → opError=1, LED=0, ready=0. Then load B=2 and press ADD → LED=5, opError=0.
- Live mode and shifts (DATA_WIDTH=8): A=0x80, B=9, op SRA → LED=0xFF. Reload B=1 → LED=0xC0 two cycles after pulse2. Op SRL → 0x40.
- Invalid opcode 0000 in RUN → opError=1, LED unchanged. Reset asserted mid-press → no load after release.
